// File: rtl/cdc_pkg.sv
// cdc_pkg: shared constants and types for the team's clock-domain-crossing blocks
package cdc_pkg;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 8;
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: NUM_STAGES-deep single-bit synchronizer with async active-low reset to 0
module sync_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic d,
  output logic q
);
  (* ASYNC_REG = "TRUE", keep = "true" *) logic [NUM_STAGES-1:0] ff;
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) ff <= '0;
    else        ff <= {ff[NUM_STAGES-2:0], d};
  assign q = ff[NUM_STAGES-1];
endmodule

// File: rtl/data_sync_rx.sv
// data_sync_rx: toggle req/ack CDC receiver presenting captured words on valid/ready with sticky overrun
module data_sync_rx
  import cdc_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 ASYNC_REQ,
  input  logic [BUS_WIDTH-1:0] ASYNC_DATA,
  output logic [BUS_WIDTH-1:0] SYNC_DATA,
  output logic                 SYNC_VALID,
  input  logic                 SYNC_READY,
  output logic                 ACK,
  output logic                 OVERRUN,
  input  logic                 OVERRUN_CLR
);
  if (NUM_STAGES < SYNC_STAGES_MIN || NUM_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("data_sync_rx: NUM_STAGES out of range");
  end
  // A REQ level held through release reaches chain_out at edge NUM_STAGES; one more edge lets prev absorb it
  localparam int BLANK = NUM_STAGES + 1;
  localparam int CW    = $clog2(BLANK + 1);
  logic          chain_out, prev, pulse, blanking;
  logic [CW-1:0] cnt;
  buf_state_t    state, state_nxt;
  logic          cap, ack_tg, ovr_set;
  sync_chain #(.NUM_STAGES(NUM_STAGES)) u_req_sync (
    .CLK  (CLK),
    .RST_n(RST_n),
    .d    (ASYNC_REQ),
    .q    (chain_out)
  );
  assign blanking = cnt != CW'(BLANK);
  assign pulse    = !blanking && (chain_out ^ prev);
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      cnt  <= '0;
      prev <= 1'b0;
    end else begin
      cnt  <= blanking ? cnt + CW'(1) : cnt;
      prev <= chain_out;
    end
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) state <= BUF_EMPTY;
    else        state <= state_nxt;
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    ack_tg    = 1'b0;
    ovr_set   = 1'b0;
    if (state == BUF_EMPTY) begin
      cap       = pulse;
      state_nxt = pulse ? BUF_FULL : BUF_EMPTY;
    end else begin
      cap       = pulse && SYNC_READY;
      ack_tg    = SYNC_READY;
      ovr_set   = pulse && !SYNC_READY;
      state_nxt = (SYNC_READY && !pulse) ? BUF_EMPTY : BUF_FULL;
    end
  end
  assign SYNC_VALID = state == BUF_FULL;
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      SYNC_DATA <= '0;
      ACK       <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      SYNC_DATA <= cap ? ASYNC_DATA : SYNC_DATA;
      ACK       <= ACK ^ ack_tg;
      OVERRUN   <= ovr_set || (OVERRUN && !OVERRUN_CLR);
    end
endmodule

// File: tb/tb_data_sync_rx.sv
// tb_data_sync_rx: scoreboard bench for data_sync_rx with NUM_STAGES=2, BUS_WIDTH=8
module tb_data_sync_rx;
  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       ASYNC_REQ = 1'b0;
  logic [7:0] ASYNC_DATA = '0;
  logic [7:0] SYNC_DATA;
  logic       SYNC_VALID;
  logic       SYNC_READY = 1'b0;
  logic       ACK;
  logic       OVERRUN;
  logic       OVERRUN_CLR = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  data_sync_rx #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .ASYNC_REQ  (ASYNC_REQ),
    .ASYNC_DATA (ASYNC_DATA),
    .SYNC_DATA  (SYNC_DATA),
    .SYNC_VALID (SYNC_VALID),
    .SYNC_READY (SYNC_READY),
    .ACK        (ACK),
    .OVERRUN    (OVERRUN),
    .OVERRUN_CLR(OVERRUN_CLR)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] d, input bit expect_delivery);
    ASYNC_DATA = d;
    ASYNC_REQ  = ~ASYNC_REQ;
    if (expect_delivery) sb.push_back(d);
  endtask
  always @(negedge CLK)
    if (RST_n && SYNC_VALID && SYNC_READY) begin
      if (sb.size() == 0) check("sb_unexpected", {24'b0, SYNC_DATA}, 32'hFFFF_FFFF);
      else check("sb_data", {24'b0, SYNC_DATA}, {24'b0, sb.pop_front()});
    end
  initial begin
    logic exp_ack;
    int   vc;
    int   seen;
    exp_ack = 1'b0;
    #2;
    check("rst_valid", SYNC_VALID, 0);
    check("rst_data", SYNC_DATA, 0);
    check("rst_ack", ACK, 0);
    check("rst_ovr", OVERRUN, 0);
    tick();
    RST_n = 1'b1;
    tick(6);
    send(8'hA5, 1);
    tick(2);
    check("t1_valid_k1", SYNC_VALID, 0);
    tick();
    check("t1_valid_k2", SYNC_VALID, 1);
    check("t1_data", SYNC_DATA, 8'hA5);
    check("t1_ack", ACK, 0);
    SYNC_READY = 1'b1;
    tick();
    SYNC_READY = 1'b0;
    exp_ack = ~exp_ack;
    check("t2_valid", SYNC_VALID, 0);
    check("t2_ack", ACK, exp_ack);
    check("t2_data", SYNC_DATA, 8'hA5);
    SYNC_READY = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      send(8'(w), 1);
      vc = 0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (SYNC_VALID) vc++;
        if (ACK !== exp_ack) begin
          seen = 1;
          break;
        end
      end
      exp_ack = ~exp_ack;
      check("t3_ack_toggle", seen, 1);
      check("t3_valid_cycles", vc, 1);
    end
    check("t3_ack", ACK, exp_ack);
    check("t3_ovr", OVERRUN, 0);
    SYNC_READY = 1'b0;
    tick(2);
    send(8'h11, 1);
    tick(3);
    check("t4_valid", SYNC_VALID, 1);
    check("t4_data_11", SYNC_DATA, 8'h11);
    send(8'h22, 0);
    tick(3);
    check("t4_data_kept", SYNC_DATA, 8'h11);
    check("t4_ovr_set", OVERRUN, 1);
    check("t4_no_ack", ACK, exp_ack);
    check("t4_valid_kept", SYNC_VALID, 1);
    OVERRUN_CLR = 1'b1;
    tick();
    OVERRUN_CLR = 1'b0;
    check("t4_ovr_clr", OVERRUN, 0);
    send(8'h33, 1);
    tick(2);
    check("t5_pre_data", SYNC_DATA, 8'h11);
    SYNC_READY = 1'b1;
    tick();
    SYNC_READY = 1'b0;
    exp_ack = ~exp_ack;
    check("t5_data", SYNC_DATA, 8'h33);
    check("t5_valid", SYNC_VALID, 1);
    check("t5_ack", ACK, exp_ack);
    check("t5_ovr", OVERRUN, 0);
    SYNC_READY = 1'b1;
    tick();
    SYNC_READY = 1'b0;
    exp_ack = ~exp_ack;
    check("t5_drain_valid", SYNC_VALID, 0);
    check("t5_drain_ack", ACK, exp_ack);
    send(8'h44, 0);
    tick(3);
    check("t7_valid_pre", SYNC_VALID, 1);
    check("t7_data_pre", SYNC_DATA, 8'h44);
    #3;
    RST_n = 1'b0;
    #1;
    check("t7_valid", SYNC_VALID, 0);
    check("t7_data", SYNC_DATA, 0);
    check("t7_ack", ACK, 0);
    check("t7_ovr", OVERRUN, 0);
    exp_ack = 1'b0;
    ASYNC_REQ = 1'b1;
    tick();
    RST_n = 1'b1;
    vc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (SYNC_VALID) vc++;
    end
    check("t6_no_spurious", vc, 0);
    send(8'h55, 1);
    tick(3);
    check("t6_valid", SYNC_VALID, 1);
    check("t6_data", SYNC_DATA, 8'h55);
    SYNC_READY = 1'b1;
    tick();
    SYNC_READY = 1'b0;
    exp_ack = ~exp_ack;
    check("t6_ack", ACK, exp_ack);
    check("t6_valid_done", SYNC_VALID, 0);
    tick(2);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
